// File: rtl/uart_mmio_controller.sv
// rtl/uart_mmio_controller.sv - memory-mapped UART controller with TX FIFO, TX sequencer, RX holding register and level irq
module uart_mmio_controller #(
   parameter int TX_FIFO_DEPTH = 4,
   parameter int PTR_W         = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_bus_we,
   input  logic        i_bus_re,
   input  logic [3:0]  i_bus_addr,
   input  logic [31:0] i_bus_wdata,
   output logic [31:0] o_bus_rdata,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_start,
   input  logic        i_tx_busy,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   input  logic        i_rx_parity_err,
   output logic        o_irq
);

   // TX sequencer states
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LAUNCH    = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(TX_FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   localparam logic [3:0] A_TXDATA = 4'h0;
   localparam logic [3:0] A_RXDATA = 4'h4;
   localparam logic [3:0] A_STATUS = 4'h8;
   localparam logic [3:0] A_CTRL   = 4'hC;

   // TX FIFO storage and bookkeeping
   logic [7:0]       r_fifo [TX_FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   // TX sequencer
   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [7:0]       r_tx_data;

   // RX holding register and sticky flags
   logic [7:0]       r_rx_buf;
   logic             r_rx_full;
   logic             r_rx_pe;
   logic             r_rx_ovr;
   logic             r_tx_ovf;

   // CTRL fields
   logic             r_tx_en;
   logic             r_rx_irq_en;
   logic             r_txe_irq_en;

   logic             r_irq;

   // Decoded bus actions
   logic             w_tx_wr;
   logic             w_status_wr;
   logic             w_ctrl_wr;
   logic             w_rx_rd;
   logic             w_tx_empty;
   logic             w_tx_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_rx_load;
   logic             w_rx_ovr_set;
   logic [31:0]      w_status;
   logic             w_unused;

   assign w_tx_wr     = i_bus_we & (i_bus_addr == A_TXDATA);
   assign w_status_wr = i_bus_we & (i_bus_addr == A_STATUS);
   assign w_ctrl_wr   = i_bus_we & (i_bus_addr == A_CTRL);
   assign w_rx_rd     = i_bus_re & (i_bus_addr == A_RXDATA);

   assign w_tx_empty  = (r_count == '0);
   assign w_tx_full   = (r_count == DEPTH_C);

   // A launch pops the head on the same edge the FSM leaves IDLE, so a full
   // FIFO can still accept a write in that cycle.
   assign w_pop       = (r_state == S_IDLE) & ~w_tx_empty & r_tx_en;
   assign w_push      = w_tx_wr & (~w_tx_full | w_pop);
   assign w_drop      = w_tx_wr & ~w_push;

   // A byte arriving while the old one is being read out replaces it cleanly.
   assign w_rx_load    = i_rx_valid & (~r_rx_full | w_rx_rd);
   assign w_rx_ovr_set = i_rx_valid & r_rx_full & ~w_rx_rd;

   assign w_unused    = ^i_bus_wdata[31:8];

   // FIFO data array; contents need no reset because count gates every read
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= i_bus_wdata[7:0];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // TX sequencer next-state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_pop) w_state_next = S_LAUNCH;
         S_LAUNCH:    w_state_next = S_WAIT_BUSY;
         S_WAIT_BUSY: if (i_tx_busy) w_state_next = S_WAIT_DONE;
         S_WAIT_DONE: if (!i_tx_busy) w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // TX sequencer state and launched byte; tx_data holds until the next launch
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_tx_data <= 8'h00;
      end else begin
         r_state <= w_state_next;
         if (w_pop) begin
            r_tx_data <= r_fifo[r_rd_ptr];
         end
      end
   end

   assign o_tx_start = (r_state == S_LAUNCH);
   assign o_tx_data  = r_tx_data;

   // RX holding register; rx_buf keeps its value after being read
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_buf  <= 8'h00;
         r_rx_full <= 1'b0;
         r_rx_pe   <= 1'b0;
      end else if (w_rx_load) begin
         r_rx_buf  <= i_rx_data;
         r_rx_full <= 1'b1;
         r_rx_pe   <= i_rx_parity_err;
      end else if (w_rx_rd) begin
         r_rx_full <= 1'b0;
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_ovr <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_rx_ovr_set) begin
            r_rx_ovr <= 1'b1;
         end else if (w_status_wr && i_bus_wdata[2]) begin
            r_rx_ovr <= 1'b0;
         end
         if (w_drop) begin
            r_tx_ovf <= 1'b1;
         end else if (w_status_wr && i_bus_wdata[6]) begin
            r_tx_ovf <= 1'b0;
         end
      end
   end

   // CTRL register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tx_en      <= 1'b1;
         r_rx_irq_en  <= 1'b0;
         r_txe_irq_en <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_tx_en      <= i_bus_wdata[0];
         r_rx_irq_en  <= i_bus_wdata[1];
         r_txe_irq_en <= i_bus_wdata[2];
      end
   end

   // Level interrupt, registered from the current state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (r_rx_full & r_rx_irq_en) |
                  (w_tx_empty & (r_state == S_IDLE) & r_txe_irq_en);
      end
   end

   assign o_irq = r_irq;

   // STATUS word assembly
   always_comb begin
      w_status                 = '0;
      w_status[0]              = r_rx_full;
      w_status[1]              = r_rx_pe;
      w_status[2]              = r_rx_ovr;
      w_status[3]              = w_tx_full;
      w_status[4]              = w_tx_empty;
      w_status[5]              = (r_state != S_IDLE);
      w_status[6]              = r_tx_ovf;
      w_status[8 +: PTR_W + 1] = r_count;
   end

   // Combinational read mux
   always_comb begin
      o_bus_rdata = '0;
      case (i_bus_addr)
         A_RXDATA: o_bus_rdata = {24'b0, r_rx_buf};
         A_STATUS: o_bus_rdata = w_status;
         A_CTRL:   o_bus_rdata = {29'b0, r_txe_irq_en, r_rx_irq_en, r_tx_en};
         default:  o_bus_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_mmio_controller.sv
// tb/tb_uart_mmio_controller.sv - self-checking bench for uart_mmio_controller
module tb_uart_mmio_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_pe = 1'b0;
   logic        irq;

   always #5 clk = ~clk;

   uart_mmio_controller #(.TX_FIFO_DEPTH(4), .PTR_W(2)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_bus_we        (we),
      .i_bus_re        (re),
      .i_bus_addr      (addr),
      .i_bus_wdata     (wdata),
      .o_bus_rdata     (rdata),
      .o_tx_data       (tx_data),
      .o_tx_start      (tx_start),
      .i_tx_busy       (tx_busy),
      .i_rx_data       (rx_data),
      .i_rx_valid      (rx_valid),
      .i_rx_parity_err (rx_pe),
      .o_irq           (irq)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] sb_tx[$];
   logic [7:0] sb_rx[$];

   int busy_len = 11 * 5208;
   bit hold = 1'b0;
   int busy_cnt = 0;
   int launches = 0;
   int launch_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // TX core model: takes a frame on each tx_start and holds busy for busy_len cycles
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         launches++;
         launch_cyc = cyc;
         if (sb_tx.size() == 0) begin
            check("tx_unexpected_launch", {24'b0, tx_data}, 32'hFFFF_FFFF);
         end else begin
            check("tx_data", {24'b0, tx_data}, {24'b0, sb_tx.pop_front()});
         end
         busy_cnt = busy_len;
      end else if (busy_cnt > 0 && !hold) begin
         busy_cnt--;
      end
      tx_busy = (busy_cnt > 0);
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; re = 1'b0; addr = a; wdata = d;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      we = 1'b0; re = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic write1(input logic [3:0] a, input logic [31:0] d);
      bus_write(a, d);
      bus_idle();
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      we = 1'b0; re = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string nm);
      logic [31:0] d;
      bus_read(a, d);
      check(nm, d, exp);
   endtask

   task automatic rx_pulse(input logic [7:0] d, input logic pe, input bit loads);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = d; rx_pe = pe;
      if (loads) sb_rx.push_back(d);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input int maxc, input string nm);
      int k = 0;
      while ((sb_tx.size() != 0 || tx_busy) && k < maxc) begin
         @(negedge clk);
         k++;
      end
      check(nm, {31'b0, (k >= maxc)}, 32'h0);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      bit          is_write;
      logic [3:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] d;
      int l0;
      int wcyc;

      vecs[0]  = '{1'b0, 4'h8, 32'h0,         32'h0000_0010};
      vecs[1]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0001};
      vecs[2]  = '{1'b0, 4'h4, 32'h0,         32'h0000_0000};
      vecs[3]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0000};
      vecs[4]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
      vecs[5]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0007};
      vecs[6]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0};
      vecs[7]  = '{1'b0, 4'h8, 32'h0,         32'h0000_0010};
      vecs[8]  = '{1'b1, 4'hE, 32'h0,         32'h0};
      vecs[9]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0007};
      vecs[10] = '{1'b0, 4'hE, 32'h0,         32'h0000_0000};
      vecs[11] = '{1'b0, 4'h9, 32'h0,         32'h0000_0000};
      vecs[12] = '{1'b1, 4'hC, 32'h0000_0001, 32'h0};
      vecs[13] = '{1'b0, 4'hC, 32'h0,         32'h0000_0001};

      // Reset held two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_tx_start", {31'b0, tx_start}, 32'h0);
      check("reset_tx_data", {24'b0, tx_data}, 32'h0);
      reset = 1'b0;

      // Register access table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].is_write) begin
            write1(vecs[i].a, vecs[i].d);
         end else begin
            bus_read(vecs[i].a, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
         end
      end
      check("irq_after_table", {31'b0, irq}, 32'h0);

      // Single full-length frame
      l0 = launches;
      sb_tx.push_back(8'h06);
      write1(4'h0, 32'h06);
      wcyc = cyc;
      bus_read(4'h8, d);
      check("tx_active_bit", d & 32'h20, 32'h20);
      check("launch_latency", launch_cyc, wcyc + 1);
      wait_drain(60000, "frame1_timeout");
      check("frame1_launches", launches - l0, 1);
      read_check(4'h8, 32'h10, "status_after_frame1");

      // Overflow with busy held from the first launch
      busy_len = 20;
      hold = 1'b1;
      l0 = launches;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) sb_tx.push_back(8'(8'h41 + i));
         bus_write(4'h0, 32'h41 + i);
      end
      bus_idle();
      read_check(4'h8, 32'h468, "status_tx_ovf_full");
      hold = 1'b0;
      wait_drain(2000, "ovf_drain_timeout");
      check("ovf_launches", launches - l0, 5);
      read_check(4'h8, 32'h50, "status_ovf_sticky");
      write1(4'h8, 32'h40);
      read_check(4'h8, 32'h10, "status_ovf_cleared");

      // Write and pop on a full FIFO in the same cycle
      l0 = launches;
      write1(4'hC, 32'h0);
      for (int i = 0; i < 4; i++) begin
         sb_tx.push_back(8'(8'hA0 + i));
         bus_write(4'h0, 32'hA0 + i);
      end
      bus_idle();
      read_check(4'h8, 32'h408, "status_full_disabled");
      bus_write(4'hC, 32'h1);
      sb_tx.push_back(8'hA4);
      bus_write(4'h0, 32'hA4);
      bus_idle();
      read_check(4'h8, 32'h428, "status_push_pop_full");
      wait_drain(2000, "pushpop_drain_timeout");
      check("pushpop_launches", launches - l0, 5);
      read_check(4'h8, 32'h10, "status_pushpop_done");

      // RX with interrupt
      write1(4'hC, 32'h3);
      rx_pulse(8'h06, 1'b0, 1'b1);
      check("rx_irq_lag", {31'b0, irq}, 32'h0);
      @(negedge clk);
      check("rx_irq_set", {31'b0, irq}, 32'h1);
      read_check(4'h8, 32'h11, "status_rx_full");
      bus_read(4'h4, d);
      check("rx_read1", d, {24'b0, sb_rx.pop_front()});
      @(negedge clk);
      check("rx_irq_clear", {31'b0, irq}, 32'h0);
      read_check(4'h8, 32'h10, "status_rx_empty");

      rx_pulse(8'h06, 1'b1, 1'b1);
      read_check(4'h8, 32'h13, "status_rx_pe");
      bus_read(4'h4, d);
      check("rx_read_pe", d, {24'b0, sb_rx.pop_front()});
      bus_read(4'h8, d);
      check("rx_full_after_pe_read", d & 32'h1, 32'h0);

      // Overrun
      rx_pulse(8'h06, 1'b0, 1'b1);
      rx_pulse(8'h07, 1'b0, 1'b0);
      read_check(4'h8, 32'h15, "status_rx_ovr");
      bus_read(4'h4, d);
      check("rx_read_ovr", d, {24'b0, sb_rx.pop_front()});
      write1(4'h8, 32'h4);
      read_check(4'h8, 32'h10, "status_ovr_cleared");

      // Read and reload in the same cycle
      rx_pulse(8'h06, 1'b0, 1'b1);
      @(negedge clk);
      re = 1'b1; addr = 4'h4; rx_valid = 1'b1; rx_data = 8'h07; rx_pe = 1'b0;
      #1 d = rdata;
      check("rx_read_same_cycle", d, {24'b0, sb_rx.pop_front()});
      sb_rx.push_back(8'h07);
      bus_idle();
      read_check(4'h8, 32'h11, "status_after_reload");
      bus_read(4'h4, d);
      check("rx_read_reloaded", d, {24'b0, sb_rx.pop_front()});

      // W1C of rx_ovr in the same cycle as a new overrun
      rx_pulse(8'h11, 1'b0, 1'b1);
      @(negedge clk);
      we = 1'b1; addr = 4'h8; wdata = 32'h4; rx_valid = 1'b1; rx_data = 8'h22; rx_pe = 1'b0;
      bus_idle();
      read_check(4'h8, 32'h15, "status_ovr_set_wins");
      write1(4'h8, 32'h4);
      read_check(4'h8, 32'h11, "status_ovr_w1c");
      bus_read(4'h4, d);
      check("rx_read_after_w1c", d, {24'b0, sb_rx.pop_front()});

      // TX-empty interrupt
      write1(4'hC, 32'h5);
      @(negedge clk);
      check("txe_irq", {31'b0, irq}, 32'h1);
      write1(4'hC, 32'h1);
      @(negedge clk);
      check("txe_irq_off", {31'b0, irq}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_mmio_controller.md
# uart_mmio_controller

Memory-mapped controller that lets the RISC-V multi-cycle core drive the UART. It sits between the processor data bus and the existing UART TX/RX cores (8 data bits, even parity, 1 stop bit, 5208 clk/bit at 50 MHz). It buffers outgoing bytes in a small TX FIFO and sequences the TX core one frame at a time. It holds received bytes with parity-error and overrun flags, and raises a level interrupt.

## Interface
- TX_FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2
- PTR_W, 2, log2(TX_FIFO_DEPTH)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- bus_we  in  1  write strobe, one cycle per access
- bus_re  in  1  read strobe; qualifies read side effects only
- bus_addr  in  4  byte offset: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CTRL; other offsets read 0, writes ignored
- bus_wdata  in  32  write data
- bus_rdata  out  32  combinational read data for bus_addr, valid whenever bus_addr is stable
- tx_data  out  8  byte to TX core; registered, stable from the LAUNCH cycle until the next launch
- tx_start  out  1  one-cycle launch pulse to TX core
- tx_busy  in  1  TX core frame in progress
- rx_data  in  8  byte from RX core
- rx_valid  in  1  one-cycle pulse: rx_data/rx_parity_err valid
- rx_parity_err  in  1  parity mismatch on this byte
- irq  out  1  registered level interrupt

## Operation
- TXDATA write: push bus_wdata[7:0]. Accepted if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle. Otherwise the byte is dropped and sticky tx_ovf is set.
- TX FSM (Moore):
  - IDLE: go to LAUNCH if FIFO non-empty and tx_en.
  - LAUNCH: tx_start=1; pop head into tx_data at entry; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when tx_busy=1.
  - WAIT_DONE: go to IDLE when tx_busy=0.
- Clearing tx_en mid-frame: the current frame completes; no new launch.
- RX, on rx_valid:
  - If rx_full=0, or an RXDATA read happens in the same cycle: load rx_buf, set rx_full=1, rx_pe=rx_parity_err.
  - Otherwise: discard the byte and set sticky rx_ovr.
- RXDATA read (bus_re, addr 0x4): returns {24'b0, rx_buf}. Clears rx_full at the edge unless reloaded in the same cycle. rx_buf itself is unchanged.
- STATUS bits:
  - [0] rx_full
  - [1] rx_pe
  - [2] rx_ovr
  - [3] tx_full
  - [4] tx_empty
  - [5] tx_active (FSM≠IDLE)
  - [6] tx_ovf
  - [10:8] tx count
  - other bits 0
- STATUS write: write-1-to-clear bits [2] and [6]; all other bits are read-only.
- CTRL bits, read/write:
  - [0] tx_en, reset 1
  - [1] rx_irq_en, reset 0
  - [2] txe_irq_en, reset 0
- irq next = (rx_full & rx_irq_en) | (tx_empty & FSM==IDLE & txe_irq_en).
- FIFO pointers wrap modulo DEPTH. Count is PTR_W+1 bits wide; full when count==DEPTH.

## Timing
- Reset values:
  - FIFO empty; FSM IDLE; tx_start=0; tx_data=0x00; irq=0
  - rx_buf=0; rx_full, rx_pe, rx_ovr, tx_ovf all 0; CTRL=0x1
- Read STATUS after reset = 0x0000_0010.
- Reset asserted mid-frame: FSM returns to IDLE and the FIFO is emptied at that edge. tx_start=0 from the next cycle. The TX core's frame in flight is not aborted by this block.
- TX latency: write committed at edge E0 into an empty FIFO in IDLE → LAUNCH at E1. tx_start is high E1→E2 exactly one cycle, and tx_data is valid from E1.
- Minimum launch-to-launch is 4 cycles, plus the tx_busy duration.
- Register writes take effect at the write edge. The irq update lags the state that causes it by one cycle.
- Simultaneous TXDATA write and pop on a full FIFO: both occur and count is unchanged.
- Simultaneous STATUS W1C and a new overrun event: the set wins.

## Test plan
- Reset held 2 cycles → STATUS=0x0000_0010, CTRL=0x0000_0001, irq=0, tx_start=0.
- Write TXDATA=0x06; TX model holds tx_busy for 11×5208 cycles → exactly one tx_start pulse, 1 cycle after the write, with tx_data=0x06. STATUS[5]=1 during the frame; STATUS=0x10 after busy falls.
- TX model holds tx_busy=1 from the first launch; write 0x41–0x46 on consecutive cycles → 0x46 dropped, STATUS[6]=1, count=4. Release busy → serial order 0x41,0x42,0x43,0x44,0x45. Writing STATUS=0x40 clears bit 6.
- CTRL=0x3; rx_valid with rx_data=0x06, rx_parity_err=0 → STATUS[0]=1, irq=1 one cycle later. RXDATA read=0x06 → STATUS[0]=0 and irq=0 the next cycle. Repeat with rx_parity_err=1 → STATUS[1]=1.
- Two rx_valid pulses (0x06, 0x07) with no read → RXDATA=0x06, STATUS[2]=1. Write STATUS=0x4 → bit 2 cleared.
- rx_full=1 with 0x06; RXDATA read in the same cycle as rx_valid with 0x07 → read returns 0x06; afterwards rx_full=1, RXDATA=0x07, STATUS[2]=0.
